// File: rtl/tqvp_jnms_pdm_pkg.sv
// Shared constants for the stereo PDM microphone peripheral: register map,
// control/status bit positions, parameter defaults and CIC width helper.
package tqvp_jnms_pdm_pkg;

    localparam int CIC_ORDER_DEF  = 3;
    localparam int DECIM_LOG2_DEF = 6;
    localparam int OUT_W_DEF      = 16;
    localparam int FIFO_DEPTH_DEF = 8;

    localparam logic [5:0] ADDR_CTRL   = 6'h00;
    localparam logic [5:0] ADDR_CLKDIV = 6'h04;
    localparam logic [5:0] ADDR_STATUS = 6'h08;
    localparam logic [5:0] ADDR_DATA   = 6'h0C;

    localparam int CTRL_EN         = 0;
    localparam int CTRL_L_EN       = 1;
    localparam int CTRL_R_EN       = 2;
    localparam int CTRL_OVF_IE     = 3;
    localparam int CTRL_CLEAR      = 4;
    localparam int CTRL_THRESH_LSB = 8;
    localparam int THRESH_W        = 5;

    localparam int STAT_OVF   = 8;
    localparam int STAT_EMPTY = 9;

    // Register growth of an N-stage CIC with ratio 2^decim_log2, plus one sign bit.
    function automatic int cic_bw(input int order, input int decim_log2);
        return order * decim_log2 + 1;
    endfunction

endpackage

// File: rtl/tqvp_jnms_cic_decim.sv
// Single-channel CIC decimator: integrators advance on in_stb, combs on dec_stb,
// output is re-centred, scaled and saturated to a signed OUT_W sample.
module tqvp_jnms_cic_decim
    import tqvp_jnms_pdm_pkg::*;
#(
    parameter int ORDER      = CIC_ORDER_DEF,
    parameter int DECIM_LOG2 = DECIM_LOG2_DEF,
    parameter int OUT_W      = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_stb,
    input  logic             in_bit,
    input  logic             dec_stb,
    output logic             out_stb,
    output logic [OUT_W-1:0] pcm
);
    localparam int BW = cic_bw(ORDER, DECIM_LOG2);
    localparam int SH = BW - 1 - OUT_W;
    localparam logic [BW:0]        OFFSET  = (BW + 1)'(1) << (BW - 2);
    localparam logic signed [BW:0] SAT_MAX = (BW + 1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [BW:0] SAT_MIN = ~SAT_MAX;

    logic [BW-1:0]      integ   [ORDER];
    logic [BW-1:0]      dly     [ORDER];
    logic [BW-1:0]      comb_in [ORDER];
    logic [BW-1:0]      comb_out;
    logic signed [BW:0] centred;
    logic signed [BW:0] scaled;
    logic [OUT_W-1:0]   sat;

    always_comb begin
        comb_out = integ[ORDER-1];
        for (int k = 0; k < ORDER; k++) begin
            comb_in[k] = comb_out;
            comb_out   = comb_out - dly[k];
        end
    end

    // Comb result is an unsigned count 0..R^N; mid-scale maps to zero.
    always_comb begin
        centred = $signed({1'b0, comb_out} - OFFSET);
        scaled  = centred >>> SH;
        if (scaled > SAT_MAX)
            sat = SAT_MAX[OUT_W-1:0];
        else if (scaled < SAT_MIN)
            sat = SAT_MIN[OUT_W-1:0];
        else
            sat = scaled[OUT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int k = 0; k < ORDER; k++) begin
                integ[k] <= '0;
                dly[k]   <= '0;
            end
            out_stb <= 1'b0;
            pcm     <= '0;
        end else begin
            out_stb <= dec_stb;
            if (in_stb) begin
                integ[0] <= integ[0] + BW'(in_bit);
                for (int k = 1; k < ORDER; k++)
                    integ[k] <= integ[k] + integ[k-1];
            end
            if (dec_stb) begin
                for (int k = 0; k < ORDER; k++)
                    dly[k] <= comb_in[k];
                pcm <= sat;
            end
        end
    end

endmodule

// File: rtl/tqvp_jnms_pdm_stereo.sv
// Stereo PDM microphone front end for TinyQV: clock divider, two CIC decimators,
// frame FIFO and register file on the peripheral bus.
module tqvp_jnms_pdm_stereo
    import tqvp_jnms_pdm_pkg::*;
#(
    parameter int CIC_ORDER  = CIC_ORDER_DEF,
    parameter int DECIM_LOG2 = DECIM_LOG2_DEF,
    parameter int OUT_W      = OUT_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = $clog2(CIC_ORDER + 1);

    logic                  ctrl_en, l_en, r_en, ovf_ie;
    logic [THRESH_W-1:0]   thresh;
    logic [7:0]            clkdiv, phase, half;
    logic                  active, pdm_clk, l_stb, r_stb, dec_stb;
    logic [DECIM_LOG2-1:0] dec_cnt;
    logic [WW-1:0]         warm_cnt;
    logic                  l_out_stb, r_out_stb, frame_stb, push_req;
    logic [OUT_W-1:0]      l_pcm, r_pcm;
    logic [31:0]           frame;
    logic [31:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count;
    logic [5:0]            level;
    logic                  full, empty, pop, push_ok, ovf;
    logic                  wr_any, wr_hi, wr_ctrl, clear;
    logic                  unused_ok;

    assign wr_any  = data_write_n != 2'b11;
    assign wr_hi   = (data_write_n == 2'b01) || (data_write_n == 2'b10);
    assign wr_ctrl = wr_any && (address == ADDR_CTRL);
    assign clear   = wr_ctrl && data_in[CTRL_CLEAR];

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_en <= 1'b0;
            l_en    <= 1'b0;
            r_en    <= 1'b0;
            ovf_ie  <= 1'b0;
            thresh  <= '0;
            clkdiv  <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en <= data_in[CTRL_EN];
                l_en    <= data_in[CTRL_L_EN];
                r_en    <= data_in[CTRL_R_EN];
                ovf_ie  <= data_in[CTRL_OVF_IE];
                if (wr_hi)
                    thresh <= data_in[CTRL_THRESH_LSB +: THRESH_W];
            end
            if (wr_any && (address == ADDR_CLKDIV))
                clkdiv <= data_in[7:0];
        end
    end

    // Left is sampled just before the falling PDM edge, right at the end of the period.
    assign active  = ctrl_en && (clkdiv >= 8'd2);
    assign half    = clkdiv >> 1;
    assign pdm_clk = active && (phase < half);
    assign l_stb   = active && (phase == half - 8'd1);
    assign r_stb   = active && (phase == clkdiv - 8'd1);
    assign dec_stb = r_stb && (dec_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst || !active)
            phase <= '0;
        else
            phase <= (phase == clkdiv - 8'd1) ? 8'd0 : phase + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst || !ctrl_en) begin
            dec_cnt  <= '1;
            warm_cnt <= WW'(CIC_ORDER);
        end else begin
            if (r_stb)
                dec_cnt <= dec_cnt - DECIM_LOG2'(1);
            if (frame_stb && (warm_cnt != '0))
                warm_cnt <= warm_cnt - WW'(1);
        end
    end

    tqvp_jnms_cic_decim #(
        .ORDER(CIC_ORDER), .DECIM_LOG2(DECIM_LOG2), .OUT_W(OUT_W)
    ) u_cic_l (
        .clk(clk), .rst(rst), .clr(!ctrl_en), .in_stb(l_stb), .in_bit(ui_in[0]),
        .dec_stb(dec_stb), .out_stb(l_out_stb), .pcm(l_pcm)
    );

    tqvp_jnms_cic_decim #(
        .ORDER(CIC_ORDER), .DECIM_LOG2(DECIM_LOG2), .OUT_W(OUT_W)
    ) u_cic_r (
        .clk(clk), .rst(rst), .clr(!ctrl_en), .in_stb(r_stb), .in_bit(ui_in[0]),
        .dec_stb(dec_stb), .out_stb(r_out_stb), .pcm(r_pcm)
    );

    assign frame_stb = l_out_stb | r_out_stb;
    assign push_req  = frame_stb && ctrl_en && (warm_cnt == '0);
    assign frame     = {r_en ? 16'($signed(r_pcm)) : 16'h0000,
                        l_en ? 16'($signed(l_pcm)) : 16'h0000};

    assign full    = count == (AW + 1)'(FIFO_DEPTH);
    assign empty   = count == '0;
    assign level   = 6'(count);
    assign pop     = (data_read_n == 2'b10) && (address == ADDR_DATA) && !empty;
    assign push_ok = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok && !clear)
            mem[wr_ptr] <= frame;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // A fresh overflow outranks a same-cycle software acknowledge.
    always_ff @(posedge clk) begin
        if (rst || clear)
            ovf <= 1'b0;
        else if (push_req && full && !pop)
            ovf <= 1'b1;
        else if (wr_hi && (address == ADDR_STATUS) && data_in[STAT_OVF])
            ovf <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            user_interrupt <= 1'b0;
        else
            user_interrupt <= ((thresh != '0) && (level >= {1'b0, thresh})) || (ovf_ie && ovf);
    end

    always_comb begin
        data_out = '0;
        case (address)
            ADDR_CTRL: begin
                data_out[CTRL_EN]     = ctrl_en;
                data_out[CTRL_L_EN]   = l_en;
                data_out[CTRL_R_EN]   = r_en;
                data_out[CTRL_OVF_IE] = ovf_ie;
                data_out[CTRL_THRESH_LSB +: THRESH_W] = thresh;
            end
            ADDR_CLKDIV: data_out[7:0] = clkdiv;
            ADDR_STATUS: begin
                data_out[5:0]       = level;
                data_out[STAT_OVF]   = ovf;
                data_out[STAT_EMPTY] = empty;
            end
            ADDR_DATA: if (!empty) data_out = mem[rd_ptr];
            default: ;
        endcase
    end

    assign uo_out     = {{6{pdm_clk}}, push_req, pdm_clk};
    assign data_ready = 1'b1;
    assign unused_ok  = &{1'b0, ui_in[7:1], data_in[31:13]};

endmodule

// File: doc/tqvp_jnms_pdm_stereo.md
TQVP_JNMS_PDM_STEREO -- requirements
Module: tqvp_jnms_pdm_stereo

Interface
REQ-001 Parameter CIC_ORDER, 3, CIC stages N (1..4).
REQ-002 Parameter DECIM_LOG2, 6, log2 of decimation ratio R (R=64).
REQ-003 Parameter OUT_W, 16, PCM sample width per channel (<=16).
REQ-004 Parameter FIFO_DEPTH, 8, frame FIFO depth (power of 2, 2..32).
REQ-005 Port clk  in  1  single clock; all logic on its rising edge.
REQ-006 Port rst  in  1  reset, synchronous, active-high.
REQ-007 Port ui_in  in  8  ui_in[0] = PDM data (already 2-cycle synchronised upstream); other bits unused.
REQ-008 Port uo_out  out  8  uo_out[1] = frame strobe; every other bit = gated PDM clock.
REQ-009 Port address  in  6; data_in  in  32; data_write_n  in  2; data_read_n  in  2; TinyQV peripheral bus, byte/half/word lane rules as the existing PDM peripheral.
REQ-010 Port data_out  out  32; data_ready  out  1 (constant 1); user_interrupt  out  1.

Function
REQ-011 Registers SHALL be: 0x00 CTRL {[0] EN, [1] L_EN, [2] R_EN, [3] OVF_IE, [4] CLEAR (write-1, self-clearing, reads 0), [12:8] THRESH}; 0x04 CLKDIV [7:0] period P; 0x08 STATUS (RO except [8]) {[5:0] level, [8] OVF (write 1 clears), [9] EMPTY}; 0x0C DATA (RO); other addresses read 0.
REQ-012 Divider phase SHALL count 0..P-1 only while EN=1 and P>=2; otherwise phase=0 and PDM clock low.
REQ-013 PDM clock SHALL be high for phase < P/2 (integer), low otherwise; output gated by EN.
REQ-014 Left bit SHALL be sampled from ui_in[0] at phase P/2-1; right bit at phase P-1; no clock other than clk is used (clock-enable strobes only).
REQ-015 Each enabled channel SHALL run an N-stage CIC: integrators at PDM rate, combs at 1/R rate, width BW = N*DECIM_LOG2+1, wrap-around (modular) arithmetic, input 0/1.
REQ-016 Channel output SHALL be sat_OUT_W((comb - 2^(BW-2)) >>> (BW-1-OUT_W)), saturating to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-017 A decimation counter counting right-bit strobes SHALL produce one frame every R PDM clocks; both channels decimate on the same strobe.
REQ-018 First N frames after EN rises SHALL be discarded (warm-up counter); later frames push {R, L} (disabled channel half = 0) one clk after the decimation strobe.
REQ-019 uo_out[1] SHALL pulse high one clk on every push attempt (including dropped frames).
REQ-020 Push while full SHALL drop the new frame, leave contents unchanged, set OVF.
REQ-021 32-bit read of DATA SHALL return head word combinationally and pop on that edge; read when empty returns 0, no pop; 8/16-bit DATA reads do not pop.
REQ-022 Simultaneous push and pop SHALL both occur; level unchanged (push into full with pop succeeds).
REQ-023 CLEAR SHALL empty the FIFO and clear OVF; CLEAR wins over a same-cycle push.
REQ-024 EN=0 SHALL clear integrators, combs, decimation and warm-up counters; FIFO and OVF retained.
REQ-025 user_interrupt SHALL equal (THRESH!=0 && level>=THRESH) || (OVF_IE && OVF), registered, updating one clk after the causing event.

Reset
REQ-026 On rst: CTRL=0, CLKDIV=0, FIFO empty, OVF=0, all filter state 0, uo_out=0, user_interrupt=0, STATUS reads 0x200.
REQ-027 rst mid-frame SHALL abandon the frame with no push.

Structure
REQ-028 Package tqvp_jnms_pdm_pkg SHALL hold register addresses, CTRL/STATUS bit positions, parameter defaults, and the BW width function.
REQ-029 One sub-module tqvp_jnms_cic_decim (single-channel CIC with clock-enable in/out strobes, clear input) SHALL be instantiated per channel; FIFO and register file inline.

Verification
REQ-030 Reset: STATUS=0x200, uo_out=0x00, user_interrupt=0, DATA read=0.
REQ-031 CLKDIV=4, CTRL=0x7: uo_out[0] period 4 clk, high 2 clk; CLKDIV=1 -> held low.
REQ-032 Defaults, ui_in[0]=1 constant, CTRL=0x7, P=4: after warm-up DATA=0x7FFF7FFF; ui_in[0]=0 -> 0x80008000; R_EN=0 -> upper half 0x0000.
REQ-033 P=8, ui_in[0] = uo_out[0] delayed 2 clk: DATA=0x80007FFF (L=+full, R=-full).
REQ-034 No reads, 9 frames after warm-up: level=8, OVF=1, irq with OVF_IE=1; 8 pops -> EMPTY=1; write 0x100 to STATUS -> OVF=0, irq low.
REQ-035 THRESH=4: irq rises one clk after 4th push, falls after pop to 3; pop coinciding with push keeps level 4 and irq high.
